// File: rtl/data_mem.sv
// Byte-maskable single-port data RAM behind a valid/ready request channel.
// Every accepted request (read or write) yields one rvalid pulse after Latency cycles.
module data_mem #(
    parameter int Xlen       = 32,
    parameter int DepthWords = 1024,
    parameter int Latency    = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              mem_valid_i,
    output logic              mem_ready_o,
    input  logic [Xlen-1:0]   mem_addr_i,
    input  logic [Xlen-1:0]   mem_wdata_i,
    input  logic [Xlen/8-1:0] mem_wmask_i,
    output logic [Xlen-1:0]   mem_rdata_o,
    output logic              mem_rvalid_o
);
    localparam int Lanes = Xlen / 8;
    localparam int OffW  = $clog2(Lanes);
    localparam int IdxW  = $clog2(DepthWords);

    typedef enum logic [1:0] {Idle, Wait, Resp} state_e;

    state_e          state_q;
    logic [3:0]      cnt_q;
    logic [Xlen-1:0] cap_q;
    logic [Xlen-1:0] rdata_q;
    logic            rvalid_q;
    logic [Xlen-1:0] mem [DepthWords];

    logic [IdxW-1:0] idx;
    logic            accept;
    logic            is_wr;
    logic [Xlen-1:0] load;
    logic            unused_addr;

    assign idx         = mem_addr_i[OffW +: IdxW];
    assign unused_addr = ^{mem_addr_i[Xlen-1:OffW+IdxW], mem_addr_i[OffW-1:0]};
    assign is_wr       = |mem_wmask_i;
    assign mem_ready_o = (state_q == Idle) && !rst_i;
    assign accept      = mem_valid_i && mem_ready_o;

    // Writes respond with zero data so the requester sees a uniform response.
    always_comb begin
        load = '0;
        if (!is_wr) load = mem[idx];
    end

    // Storage has no reset; a write commits on its accept edge.
    always_ff @(posedge clk_i) begin
        if (accept && is_wr) begin
            for (int b = 0; b < Lanes; b++) begin
                if (mem_wmask_i[b]) mem[idx][b*8 +: 8] <= mem_wdata_i[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= Idle;
            cnt_q    <= '0;
            cap_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= 1'b0;
            case (state_q)
                Idle: begin
                    if (accept) begin
                        cnt_q <= 4'(Latency - 1);
                        if (Latency == 1) begin
                            state_q  <= Resp;
                            rdata_q  <= load;
                            rvalid_q <= 1'b1;
                        end else begin
                            state_q <= Wait;
                            cap_q   <= load;
                        end
                    end
                end
                Wait: begin
                    cnt_q <= cnt_q - 4'd1;
                    // rdata only updates on entry to Resp so it holds while waiting.
                    if (cnt_q <= 4'd1) begin
                        state_q  <= Resp;
                        rdata_q  <= cap_q;
                        rvalid_q <= 1'b1;
                    end
                end
                Resp:    state_q <= Idle;
                default: state_q <= Idle;
            endcase
        end
    end

    assign mem_rdata_o  = rdata_q;
    assign mem_rvalid_o = rvalid_q;
endmodule

// File: tb/tb_data_mem.sv
// Randomized bench for data_mem at Latency 1, 3 and 4 against a word-array reference.
module tb_data_mem;
    int n_chk  = 0;
    int n_fail = 0;
    bit done [3];
    logic clk = 1'b0;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    genvar k;
    for (k = 0; k < 3; k++) begin : g_inst
        localparam int L = (k == 0) ? 1 : (k == 1) ? 3 : 4;

        logic        rst, valid, ready, rvalid;
        logic [31:0] addr, wdata, rdata;
        logic [3:0]  wmask;
        logic [31:0] ref_mem [1024];
        logic [31:0] last_rd;

        data_mem #(.Xlen(32), .DepthWords(1024), .Latency(L)) dut (
            .clk_i(clk), .rst_i(rst), .mem_valid_i(valid), .mem_ready_o(ready),
            .mem_addr_i(addr), .mem_wdata_i(wdata), .mem_wmask_i(wmask),
            .mem_rdata_o(rdata), .mem_rvalid_o(rvalid)
        );

        task automatic tick();
            @(negedge clk);
            #1;
        endtask

        // Reference: word array indexed by address bits [11:2]; writes answer 0.
        task automatic model(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                             output logic [31:0] exp);
            if (m != 4'h0) begin
                for (int b = 0; b < 4; b++)
                    if (m[b]) ref_mem[a[11:2]][b*8 +: 8] = d[b*8 +: 8];
                exp = 32'h0;
            end else begin
                exp = ref_mem[a[11:2]];
            end
        endtask

        // Issue one request; optionally present the next request during the busy window.
        task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                              input bit hold, input logic [31:0] na, input logic [31:0] nd,
                              input logic [3:0] nm, output logic [31:0] got);
            int w;
            logic [31:0] exp;
            addr = a; wdata = d; wmask = m; valid = 1'b1;
            w = 0;
            while (!ready && w < 50) begin
                tick();
                w++;
            end
            if (!ready) chk($sformatf("L%0d accept_timeout", L), 32'(ready), 32'h1);
            model(a, d, m, exp);
            got = 32'h0;
            for (int n = 1; n <= L + 1; n++) begin
                tick();
                if (n < L) begin
                    chk($sformatf("L%0d rvalid_early n=%0d", L, n), 32'(rvalid), 32'h0);
                    chk($sformatf("L%0d ready_busy n=%0d", L, n), 32'(ready), 32'h0);
                    chk($sformatf("L%0d rdata_hold n=%0d", L, n), rdata, last_rd);
                end else if (n == L) begin
                    chk($sformatf("L%0d rvalid_resp a=%h", L, a), 32'(rvalid), 32'h1);
                    chk($sformatf("L%0d ready_resp", L), 32'(ready), 32'h0);
                    chk($sformatf("L%0d rdata a=%h m=%h", L, a, m), rdata, exp);
                    got = rdata;
                    last_rd = exp;
                end else begin
                    chk($sformatf("L%0d rvalid_after", L), 32'(rvalid), 32'h0);
                    chk($sformatf("L%0d ready_after", L), 32'(ready), 32'h1);
                    chk($sformatf("L%0d rdata_hold_after", L), rdata, last_rd);
                end
                if (n == 1) begin
                    if (hold) begin
                        addr = na; wdata = nd; wmask = nm;
                    end else begin
                        valid = 1'b0;
                    end
                end
            end
        endtask

        initial begin
            logic [31:0] got;
            logic [31:0] ra [200];
            logic [31:0] rd [200];
            logic [3:0]  rm [200];
            bit          rh [200];
            rst = 1'b1; valid = 1'b0; addr = '0; wdata = '0; wmask = '0; last_rd = '0;
            repeat (3) tick();
            chk($sformatf("L%0d reset_ready", L), 32'(ready), 32'h0);
            chk($sformatf("L%0d reset_rvalid", L), 32'(rvalid), 32'h0);
            chk($sformatf("L%0d reset_rdata", L), rdata, 32'h0);
            rst = 1'b0;
            #1;
            chk($sformatf("L%0d ready_after_reset", L), 32'(ready), 32'h1);

            for (int i = 0; i < 1024; i++)
                do_req(32'(i * 4), $urandom, 4'hF, 1'b0, '0, '0, '0, got);

            do_req(32'h10, 32'hDEADBEEF, 4'hF, 1'b0, '0, '0, '0, got);
            chk($sformatf("L%0d wr_resp_zero", L), got, 32'h0);
            do_req(32'h10, 32'h0, 4'h0, 1'b0, '0, '0, '0, got);
            chk($sformatf("L%0d rd_deadbeef", L), got, 32'hDEADBEEF);
            do_req(32'h20, 32'h11223344, 4'hF, 1'b0, '0, '0, '0, got);
            do_req(32'h20, 32'hAA000000, 4'h8, 1'b0, '0, '0, '0, got);
            do_req(32'h20, 32'h0, 4'h0, 1'b0, '0, '0, '0, got);
            chk($sformatf("L%0d byte_mask", L), got, 32'hAA223344);
            do_req(32'h1004, 32'h5A5A5A5A, 4'hF, 1'b0, '0, '0, '0, got);
            do_req(32'h4, 32'h0, 4'h0, 1'b0, '0, '0, '0, got);
            chk($sformatf("L%0d alias_4", L), got, 32'h5A5A5A5A);
            do_req(32'h6, 32'h0, 4'h0, 1'b0, '0, '0, '0, got);
            chk($sformatf("L%0d alias_6", L), got, 32'h5A5A5A5A);

            for (int i = 0; i < 200; i++) begin
                ra[i] = $urandom;
                rd[i] = $urandom;
                rm[i] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                rh[i] = ($urandom_range(0, 1) == 1) && (i < 199);
            end
            for (int i = 0; i < 200; i++)
                do_req(ra[i], rd[i], rm[i], rh[i],
                       ra[(i + 1) % 200], rd[(i + 1) % 200], rm[(i + 1) % 200], got);

            // Reset while a read of 0x20 is in flight: no response, memory kept.
            addr = 32'h20; wdata = '0; wmask = 4'h0; valid = 1'b1;
            @(posedge clk);
            #1;
            valid = 1'b0;
            if (L >= 3) begin
                repeat (2) tick();
                chk($sformatf("L%0d rvalid_before_rst", L), 32'(rvalid), 32'h0);
            end
            rst = 1'b1;
            for (int n = 0; n < 3; n++) begin
                tick();
                chk($sformatf("L%0d midrst_ready", L), 32'(ready), 32'h0);
                chk($sformatf("L%0d midrst_rvalid", L), 32'(rvalid), 32'h0);
                chk($sformatf("L%0d midrst_rdata", L), rdata, 32'h0);
            end
            rst = 1'b0;
            #1;
            chk($sformatf("L%0d ready_release", L), 32'(ready), 32'h1);
            last_rd = 32'h0;
            for (int n = 0; n < 6; n++) begin
                tick();
                chk($sformatf("L%0d no_stale_rvalid", L), 32'(rvalid), 32'h0);
            end
            do_req(32'h20, 32'h0, 4'h0, 1'b0, '0, '0, '0, got);
            chk($sformatf("L%0d mem_after_rst", L), got, ref_mem[8]);
            done[k] = 1'b1;
        end
    end

    initial begin
        fork
            wait (done[0] && done[1] && done[2]);
            #900000;
        join_any
        if (!(done[0] && done[1] && done[2]))
            chk("global_timeout", {29'h0, done[2], done[1], done[0]}, 32'h7);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
